// File: rtl/sa_out_port_alloc.sv
// Output-port switch allocator: round-robin grant, wormhole lock,
// one-deep output register with valid/ready and congestion count.
module sa_out_port_alloc #(
    parameter int          NUM_IN    = 5,
    parameter int          DATASIZE  = 40,
    parameter logic [3:0]  PORT_CODE = 4'b1000,
    parameter int          WIDTH     = 3
) (
    input  logic                         rc_clk,
    input  logic                         rst_n,
    input  logic [4*NUM_IN-1:0]          req_dir_in,
    input  logic [DATASIZE*NUM_IN-1:0]   req_data_in,
    output logic [NUM_IN-1:0]            grant_out,
    output logic [DATASIZE-1:0]          data_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [WIDTH:0]               pressure_out
);

    localparam int PW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int PMAX = (1 << (WIDTH + 1)) - 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [NUM_IN-1:0]     grant_q, grant_d;
    logic [DATASIZE-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic [WIDTH:0]        pres_q, pres_d;

    logic [NUM_IN-1:0]     req;
    logic                  slot_ok;
    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic                  take;
    logic [PW-1:0]         sel_idx;
    logic [DATASIZE-1:0]   sel_flit;
    logic [1:0]            sel_type;

    // decode per-input requests for this output
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            req[i] = (req_dir_in[4*i +: 4] == PORT_CODE);
        end
    end

    assign slot_ok = !valid_q || ready_in;

    // round-robin search starting at rr pointer
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (int'(rr_q) + k) % NUM_IN;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // pick the granted input: any winner when idle, only the owner when locked
    always_comb begin
        take    = 1'b0;
        sel_idx = win_idx;
        if (state_q == LOCKED) begin
            sel_idx = owner_q;
            take    = slot_ok && req[owner_q];
        end else begin
            take    = slot_ok && win_found;
        end
    end

    assign sel_flit = req_data_in[int'(sel_idx)*DATASIZE +: DATASIZE];
    assign sel_type = sel_flit[1:0];

    // state register
    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state: lock on head, release on tail
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (take && sel_type == 2'b01) state_d = LOCKED;
            LOCKED: if (take && sel_type == 2'b10) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // next values of output register, pointer, owner and pressure
    always_comb begin
        int cnt;
        grant_d = '0;
        data_d  = data_q;
        valid_d = ready_in ? 1'b0 : valid_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt     = int'(valid_q);
        if (take) begin
            grant_d[sel_idx] = 1'b1;
            data_d           = sel_flit;
            valid_d          = 1'b1;
        end
        if (take && state_q == IDLE) begin
            if (int'(win_idx) == NUM_IN - 1) rr_d = '0;
            else                             rr_d = win_idx + PW'(1);
            if (sel_type == 2'b01) owner_d = win_idx;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            cnt = cnt + int'(req[i]);
        end
        if (cnt > PMAX) cnt = PMAX;
        pres_d = (WIDTH+1)'(cnt);
    end

    // datapath and control registers
    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= '0;
            owner_q <= '0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pres_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pres_q  <= pres_d;
        end
    end

    assign grant_out    = grant_q;
    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign pressure_out = pres_q;

endmodule

// File: tb/tb_sa_out_port_alloc.sv
// Scoreboard bench for sa_out_port_alloc: directed vectors,
// expected grants queued by the driver, checked by a monitor.
module tb_sa_out_port_alloc;

    localparam int N  = 5;
    localparam int DS = 40;
    localparam logic [3:0] PC = 4'b1000;

    logic              rc_clk;
    logic              rst_n;
    logic [4*N-1:0]    req_dir_in;
    logic [DS*N-1:0]   req_data_in;
    logic [N-1:0]      grant_out;
    logic [DS-1:0]     data_out;
    logic              valid_out;
    logic              ready_in;
    logic [3:0]        pressure_out;

    sa_out_port_alloc #(
        .NUM_IN(N), .DATASIZE(DS), .PORT_CODE(PC), .WIDTH(3)
    ) dut (
        .rc_clk(rc_clk),
        .rst_n(rst_n),
        .req_dir_in(req_dir_in),
        .req_data_in(req_data_in),
        .grant_out(grant_out),
        .data_out(data_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .pressure_out(pressure_out)
    );

    initial rc_clk = 1'b0;
    always #5 rc_clk = ~rc_clk;

    int checks = 0;
    int errors = 0;
    logic [N+DS-1:0] exp_q[$];
    logic [3:0]  dir[N];
    logic [DS-1:0] dat[N];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DS-1:0] flit(int id, int seq, logic [1:0] t);
        return (DS'(id) << 16) | (DS'(seq) << 8) | DS'(t);
    endfunction

    task automatic push(int w, logic [DS-1:0] d);
        logic [N-1:0] g;
        g = N'(1 << w);
        exp_q.push_back({g, d});
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            dir[i] = 4'hF;
            dat[i] = '0;
        end
    endtask

    task automatic step();
        for (int i = 0; i < N; i++) begin
            req_dir_in[4*i +: 4]    = dir[i];
            req_data_in[DS*i +: DS] = dat[i];
        end
        @(posedge rc_clk);
        #1;
    endtask

    // monitor: every grant must match the oldest expectation
    always @(negedge rc_clk) begin
        logic [N+DS-1:0] e;
        if (rst_n && grant_out != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 64'(grant_out), 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("grant", 64'(grant_out), 64'(e[N+DS-1:DS]));
                chk("data", 64'(data_out), 64'(e[DS-1:0]));
                chk("valid_on_grant", 64'(valid_out), 64'h1);
            end
        end
    end

    int w2[6] = '{4, 0, 1, 4, 0, 1};

    initial begin
        rst_n = 1'b0;
        ready_in = 1'b1;
        clr();
        req_dir_in = '1;
        req_data_in = '0;
        repeat (2) @(posedge rc_clk);
        #1;
        chk("rst_grant", 64'(grant_out), 64'h0);
        chk("rst_valid", 64'(valid_out), 64'h0);
        chk("rst_data", 64'(data_out), 64'h0);
        chk("rst_pressure", 64'(pressure_out), 64'h0);
        rst_n = 1'b1;

        // single flit from input 2
        dir[2] = PC; dat[2] = flit(2, 1, 2'b11);
        push(2, flit(2, 1, 2'b11));
        step();
        chk("t1_pressure", 64'(pressure_out), 64'h1);
        clr();

        // inputs 0,1,4 continuously; rr starts at 3
        for (int c = 0; c < 6; c++) begin
            dir[0] = PC; dat[0] = flit(0, 10 + c, 2'b11);
            dir[1] = PC; dat[1] = flit(1, 10 + c, 2'b11);
            dir[4] = PC; dat[4] = flit(4, 10 + c, 2'b11);
            push(w2[c], flit(w2[c], 10 + c, 2'b11));
            step();
        end
        clr();

        // wormhole: input 3 head/body/tail with input 0 contending
        dir[0] = PC; dat[0] = flit(0, 20, 2'b11);
        dir[3] = PC; dat[3] = flit(3, 20, 2'b01);
        push(3, flit(3, 20, 2'b01));
        step();
        dat[3] = flit(3, 21, 2'b00);
        push(3, flit(3, 21, 2'b00));
        step();
        dat[3] = flit(3, 22, 2'b10);
        push(3, flit(3, 22, 2'b10));
        step();
        dir[3] = 4'hF;
        push(0, flit(0, 20, 2'b11));
        step();
        clr();
        step();
        chk("drain_valid", 64'(valid_out), 64'h0);

        // backpressure with two requesters
        ready_in = 1'b0;
        dir[1] = PC; dat[1] = flit(1, 40, 2'b11);
        dir[2] = PC; dat[2] = flit(2, 40, 2'b11);
        push(1, flit(1, 40, 2'b11));
        step();
        chk("bp_first_pressure", 64'(pressure_out), 64'h2);
        for (int c = 0; c < 4; c++) begin
            dat[1] = flit(1, 41 + c, 2'b11);
            step();
            chk("bp_grant", 64'(grant_out), 64'h0);
            chk("bp_data", 64'(data_out), 64'(flit(1, 40, 2'b11)));
            chk("bp_valid", 64'(valid_out), 64'h1);
            chk("bp_pressure", 64'(pressure_out), 64'h3);
        end
        ready_in = 1'b1;
        push(2, flit(2, 40, 2'b11));
        step();
        chk("bp_release_valid", 64'(valid_out), 64'h1);
        clr();
        step();

        // no matching direction codes
        dir[0] = 4'hF; dir[1] = 4'b0001; dir[2] = 4'b0010;
        dir[3] = 4'b0100; dir[4] = 4'b1001;
        for (int i = 0; i < N; i++) dat[i] = flit(i, 50, 2'b11);
        step();
        step();
        chk("nomatch_pressure", 64'(pressure_out), 64'h0);
        chk("nomatch_valid", 64'(valid_out), 64'h0);
        clr();

        // reset in the middle of a locked packet
        dir[3] = PC; dat[3] = flit(3, 60, 2'b01);
        push(3, flit(3, 60, 2'b01));
        step();
        dat[3] = flit(3, 61, 2'b00);
        push(3, flit(3, 61, 2'b00));
        step();
        clr();
        @(negedge rc_clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 64'(grant_out), 64'h0);
        chk("mid_rst_valid", 64'(valid_out), 64'h0);
        chk("mid_rst_data", 64'(data_out), 64'h0);
        chk("mid_rst_pressure", 64'(pressure_out), 64'h0);
        step();
        step();
        rst_n = 1'b1;
        dir[1] = PC; dat[1] = flit(1, 70, 2'b01);
        dir[3] = PC; dat[3] = flit(3, 62, 2'b00);
        push(1, flit(1, 70, 2'b01));
        step();
        dat[1] = flit(1, 71, 2'b10);
        dat[3] = flit(3, 63, 2'b00);
        push(1, flit(1, 71, 2'b10));
        step();
        clr();
        step();
        step();
        @(negedge rc_clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
